// File: rtl/regfile_pkg.sv
// Shared constants and elaboration helpers for the parameterised register file.
package regfile_pkg;

    localparam int RF_DEF_WIDTH = 32;
    localparam int RF_DEF_DEPTH = 32;
    localparam int RF_DEF_NRD   = 2;

    // Address width needed to index `value` entries (minimum 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
            result = result + 32'sd1;
        end
        if (result == 32'sd0) begin
            result = 32'sd1;
        end else begin
            result = result;
        end
        return result;
    endfunction

    // Addresses can exceed DEPTH when DEPTH is not a power of two.
    function automatic logic addr_in_range(input int addr, input int depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/regfile_rd_mux.sv
// One read port's combinational selector: register pick, write-first bypass,
// hard-wired zero register and out-of-range zeroing.
module regfile_rd_mux
    import regfile_pkg::*;
#(
    parameter int  WIDTH    = RF_DEF_WIDTH,
    parameter int  DEPTH    = RF_DEF_DEPTH,
    parameter int  ZERO_REG = 1,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic [WIDTH-1:0] regs_i [DEPTH],
    input  logic [AW-1:0]    raddr_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             oor_o
);

    // Priority: out-of-range, then zero register, then bypass, then storage.
    always_comb begin
        rdata_o = {WIDTH{1'b0}};
        oor_o   = 1'b0;
        if (!addr_in_range(32'(raddr_i), DEPTH)) begin
            rdata_o = {WIDTH{1'b0}};
            oor_o   = 1'b1;
        end else if ((ZERO_REG != 32'sd0) && (raddr_i == {AW{1'b0}})) begin
            rdata_o = {WIDTH{1'b0}};
        end else if (wr_en_i && (waddr_i == raddr_i)) begin
            rdata_o = wdata_i;
        end else begin
            rdata_o = regs_i[raddr_i];
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Parameterised multi-read-port register file with registered read data,
// write-first bypass and a sticky out-of-range error flag.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int  WIDTH    = RF_DEF_WIDTH,
    parameter int  DEPTH    = RF_DEF_DEPTH,
    parameter int  NRD      = RF_DEF_NRD,
    parameter int  ZERO_REG = 1,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [NRD-1:0]       ren,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rdata,
    output logic [NRD-1:0]       rvalid,
    output logic                 err
);

    logic [WIDTH-1:0]     regs_q [DEPTH];
    logic [WIDTH-1:0]     regs_d [DEPTH];
    logic [NRD*WIDTH-1:0] rdata_q;
    logic [NRD*WIDTH-1:0] rdata_d;
    logic [NRD-1:0]       rvalid_q;
    logic [NRD-1:0]       rvalid_d;
    logic                 err_q;
    logic                 err_d;

    logic                 waddr_ok_s;
    logic                 wr_zero_s;
    logic                 wr_en_s;
    logic [WIDTH-1:0]     mux_data_s [NRD];
    logic [NRD-1:0]       mux_oor_s;

    // Qualify the write: in range and not aimed at the hard-wired zero register.
    always_comb begin
        waddr_ok_s = addr_in_range(32'(waddr), DEPTH);
        wr_zero_s  = (ZERO_REG != 32'sd0) && (waddr == {AW{1'b0}});
        wr_en_s    = we && waddr_ok_s && !wr_zero_s;
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        regfile_rd_mux #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG)
        ) u_rd_mux (
            .regs_i  (regs_q),
            .raddr_i (raddr[p*AW +: AW]),
            .wr_en_i (wr_en_s),
            .waddr_i (waddr),
            .wdata_i (wdata),
            .rdata_o (mux_data_s[p]),
            .oor_o   (mux_oor_s[p])
        );
    end

    // Next-state for storage, read outputs and the sticky error flag.
    always_comb begin
        regs_d   = regs_q;
        rdata_d  = rdata_q;
        rvalid_d = {NRD{1'b0}};
        if (wr_en_s) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d = regs_q;
        end
        for (int p = 0; p < NRD; p++) begin
            if (ren[p]) begin
                rdata_d[p*WIDTH +: WIDTH] = mux_data_s[p];
                rvalid_d[p]               = 1'b1;
            end else begin
                rdata_d[p*WIDTH +: WIDTH] = rdata_q[p*WIDTH +: WIDTH];
                rvalid_d[p]               = 1'b0;
            end
        end
        err_d = err_q | (we & ~waddr_ok_s) | (|(ren & mux_oor_s));
    end

    // State update; reset also discards any access presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
            rdata_q  <= {(NRD*WIDTH){1'b0}};
            rvalid_q <= {NRD{1'b0}};
            err_q    <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench: a default instance (32x32, 2 ports) and a 24-deep 4-port instance.
module tb_regfile_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         d0_rst = 1'b0, d0_we = 1'b0;
    logic [4:0]   d0_waddr = 5'd0;
    logic [31:0]  d0_wdata = 32'd0;
    logic [1:0]   d0_ren = 2'd0;
    logic [9:0]   d0_raddr = 10'd0;
    logic [63:0]  d0_rdata;
    logic [1:0]   d0_rvalid;
    logic         d0_err;

    logic         d1_rst = 1'b0, d1_we = 1'b0;
    logic [4:0]   d1_waddr = 5'd0;
    logic [31:0]  d1_wdata = 32'd0;
    logic [3:0]   d1_ren = 4'd0;
    logic [19:0]  d1_raddr = 20'd0;
    logic [127:0] d1_rdata;
    logic [3:0]   d1_rvalid;
    logic         d1_err;

    regfile_param u_dut0 (
        .clk(clk), .rst(d0_rst), .we(d0_we), .waddr(d0_waddr), .wdata(d0_wdata),
        .ren(d0_ren), .raddr(d0_raddr), .rdata(d0_rdata), .rvalid(d0_rvalid), .err(d0_err)
    );

    regfile_param #(.WIDTH(32), .DEPTH(24), .NRD(4), .ZERO_REG(1)) u_dut1 (
        .clk(clk), .rst(d1_rst), .we(d1_we), .waddr(d1_waddr), .wdata(d1_wdata),
        .ren(d1_ren), .raddr(d1_raddr), .rdata(d1_rdata), .rvalid(d1_rvalid), .err(d1_err)
    );

    typedef struct {
        int          d;
        int          port;   // -1 selects the err flag
        logic [31:0] rdata;
        logic        rvalid;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem  [2][32];
    logic [31:0] hold [2][4];
    logic        merr [2];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_rdata(input int d, input int p);
        if (d == 0) return d0_rdata[p*32 +: 32];
        else        return d1_rdata[p*32 +: 32];
    endfunction

    function automatic logic obs_rvalid(input int d, input int p);
        if (d == 0) return d0_rvalid[p];
        else        return d1_rvalid[p];
    endfunction

    task automatic compare_due();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.port < 0) begin
                chk_eq($sformatf("d%0d_err", e.d), {31'd0, (e.d == 0) ? d0_err : d1_err}, {31'd0, e.rvalid});
            end else begin
                chk_eq($sformatf("d%0d_p%0d_rvalid", e.d, e.port), {31'd0, obs_rvalid(e.d, e.port)}, {31'd0, e.rvalid});
                chk_eq($sformatf("d%0d_p%0d_rdata", e.d, e.port), obs_rdata(e.d, e.port), e.rdata);
            end
        end
    endtask

    // One cycle on DUT d: check last cycle's results, drive new inputs, predict.
    task automatic step(input int d, input bit r, input bit w, input int wa, input logic [31:0] wd,
                        input logic [3:0] rn, input int a0, input int a1, input int a2, input int a3);
        int          a[4];
        int          depth, nrd;
        bit          wv;
        logic [31:0] val;
        a = '{a0, a1, a2, a3};
        depth = (d == 0) ? 32 : 24;
        nrd   = (d == 0) ? 2 : 4;
        @(negedge clk);
        compare_due();
        d0_rst = 1'b0; d0_we = 1'b0; d0_ren = 2'd0;
        d1_rst = 1'b0; d1_we = 1'b0; d1_ren = 4'd0;
        if (d == 0) begin
            d0_rst = r; d0_we = w; d0_waddr = 5'(wa); d0_wdata = wd; d0_ren = rn[1:0];
            d0_raddr = {5'(a[1]), 5'(a[0])};
        end else begin
            d1_rst = r; d1_we = w; d1_waddr = 5'(wa); d1_wdata = wd; d1_ren = rn;
            d1_raddr = {5'(a[3]), 5'(a[2]), 5'(a[1]), 5'(a[0])};
        end
        if (r) begin
            for (int i = 0; i < 32; i++) mem[d][i] = 32'd0;
            for (int p = 0; p < 4; p++) hold[d][p] = 32'd0;
            merr[d] = 1'b0;
            for (int p = 0; p < nrd; p++) sb_q.push_back('{d, p, 32'd0, 1'b0});
        end else begin
            wv = w && (wa < depth) && (wa != 0);
            for (int p = 0; p < nrd; p++) begin
                if (rn[p]) begin
                    if (a[p] >= depth || a[p] == 0) val = 32'd0;
                    else if (wv && wa == a[p])     val = wd;
                    else                           val = mem[d][a[p]];
                    if (a[p] >= depth) merr[d] = 1'b1;
                    hold[d][p] = val;
                    sb_q.push_back('{d, p, val, 1'b1});
                end else begin
                    sb_q.push_back('{d, p, hold[d][p], 1'b0});
                end
            end
            if (w && wa >= depth) merr[d] = 1'b1;
            if (wv) mem[d][wa] = wd;
        end
        sb_q.push_back('{d, -1, 32'd0, merr[d]});
    endtask

    initial begin
        // Reset both instances, then read immediately after reset.
        step(0, 1, 0, 0, 32'd0, 4'b0011, 5, 6, 0, 0);
        step(1, 1, 0, 0, 32'd0, 4'b1111, 1, 2, 3, 4);
        step(1, 0, 0, 0, 32'd0, 4'b1111, 0, 5, 17, 23);
        step(0, 0, 0, 0, 32'd0, 4'b0011, 31, 5, 0, 0);

        // Register k holds k; port 1 mirrors port 0 to check identical data.
        for (int k = 1; k < 32; k++) step(0, 0, 1, k, 32'(k), 4'b0000, 0, 0, 0, 0);
        for (int k = 0; k < 32; k++) step(0, 0, 0, 0, 32'd0, 4'b0011, k, k, 0, 0);

        // Write-first bypass on port 1, then confirm the value stuck.
        step(0, 0, 1, 5, 32'hDEADBEEF, 4'b0010, 0, 5, 0, 0);
        step(0, 0, 0, 0, 32'd0, 4'b0011, 5, 5, 0, 0);

        // Zero register ignores writes without raising err; bypass also returns 0.
        step(0, 0, 1, 0, 32'h00001234, 4'b0001, 0, 0, 0, 0);
        step(0, 0, 0, 0, 32'd0, 4'b0011, 0, 1, 0, 0);

        // 24-deep instance: fill, then out-of-range write and read.
        for (int k = 0; k < 24; k++) step(1, 0, 1, k, 32'hA5000000 + 32'(k), 4'b0000, 0, 0, 0, 0);
        step(1, 0, 1, 30, 32'hBAD0BAD0, 4'b0000, 0, 0, 0, 0);
        step(1, 0, 0, 0, 32'd0, 4'b0001, 30, 0, 0, 0);
        for (int k = 0; k < 24; k += 4) step(1, 0, 0, 0, 32'd0, 4'b1111, k, k+1, k+2, k+3);
        step(1, 0, 0, 0, 32'd0, 4'b1111, 12, 12, 12, 12);

        // Sparse read enables: ports 0 and 2 must hold.
        step(1, 0, 1, 7, 32'h77770007, 4'b0000, 0, 0, 0, 0);
        step(1, 0, 1, 9, 32'h99990009, 4'b0000, 0, 0, 0, 0);
        step(1, 0, 0, 0, 32'd0, 4'b1111, 1, 2, 3, 4);
        step(1, 0, 0, 0, 32'd0, 4'b1010, 7, 7, 9, 9);
        step(1, 0, 0, 0, 32'd0, 4'b0000, 0, 0, 0, 0);

        // Reset with a concurrent write, on both instances (d1 also clears err).
        for (int k = 1; k < 32; k++) step(0, 0, 1, k, 32'hC0DE0000 + 32'(k), 4'b0000, 0, 0, 0, 0);
        step(0, 1, 1, 3, 32'hFFFFFFFF, 4'b0011, 3, 3, 0, 0);
        step(0, 0, 0, 0, 32'd0, 4'b0011, 3, 4, 0, 0);
        step(1, 1, 1, 3, 32'hFFFFFFFF, 4'b1111, 3, 3, 30, 3);
        step(1, 0, 0, 0, 32'd0, 4'b1111, 3, 7, 9, 23);

        // Mixed random traffic on the default instance.
        for (int i = 0; i < 80; i++) begin
            step(0, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom,
                 4'($urandom_range(0, 3)), $urandom_range(0, 31), $urandom_range(0, 31), 0, 0);
        end
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 23), $urandom,
                 4'($urandom_range(0, 15)), $urandom_range(0, 23), $urandom_range(0, 23),
                 $urandom_range(0, 23), $urandom_range(0, 23));
        end

        @(negedge clk);
        compare_due();
        chk_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 32: data width in bits of each register.
REQ-002 The block SHALL have the parameter DEPTH, default 32: number of registers, 2..256.
REQ-003 The block SHALL have the parameter NRD, default 2: number of independent read ports, 1..4.
REQ-004 The block SHALL have the parameter ZERO_REG, default 1: when 1, register 0 always reads 0 and ignores writes.
REQ-005 The block SHALL define AW = clog2(DEPTH) as a local constant, not a parameter.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 The block SHALL have port we, input, 1 bit: write enable.
REQ-009 The block SHALL have port waddr, input, AW bits: write address.
REQ-010 The block SHALL have port wdata, input, WIDTH bits: write data.
REQ-011 The block SHALL have port ren, input, NRD bits: per-port read request.
REQ-012 The block SHALL have port raddr, input, NRD*AW bits: packed read addresses, port p at bits [p*AW +: AW].
REQ-013 The block SHALL have port rdata, output, NRD*WIDTH bits: packed registered read data, port p at bits [p*WIDTH +: WIDTH].
REQ-014 The block SHALL have port rvalid, output, NRD bits: per-port flag marking rdata valid.
REQ-015 The block SHALL have port err, output, 1 bit: sticky out-of-range access flag.

Function
REQ-016 The block SHALL write wdata to register waddr at the clock edge when we=1, waddr<DEPTH and rst=0.
REQ-017 The block SHALL drop a write when we=1 and waddr>=DEPTH, and SHALL set err.
REQ-018 The block SHALL drop writes to address 0 when ZERO_REG=1, without setting err.
REQ-019 Each read port p with ren[p]=1 SHALL present data for raddr[p] on rdata[p] with rvalid[p]=1 one cycle later; latency is exactly 1.
REQ-020 When ren[p]=0, rvalid[p] SHALL be 0 next cycle and rdata[p] SHALL hold its previous value.
REQ-021 A read of waddr in the same cycle as a valid write SHALL return the new wdata (write-first bypass), except address 0 when ZERO_REG=1, which returns 0.
REQ-022 A read with raddr[p]>=DEPTH SHALL return 0 with rvalid[p]=1 and SHALL set err.
REQ-023 Multiple ports reading the same address in the same cycle SHALL all return identical data.
REQ-024 err SHALL stay 1 once set until rst.

Reset
REQ-025 While rst=1 at a clock edge, all registers, rdata, rvalid and err SHALL become 0.
REQ-026 While rst=1, writes and reads presented in the same cycle SHALL be ignored.
REQ-027 A read issued in the first cycle after rst deasserts SHALL return 0 for every address.

Structure
REQ-028 The package regfile_pkg SHALL hold the default WIDTH/DEPTH/NRD constants and the clog2 function.
REQ-029 Each read port SHALL use one instance of the sub-module regfile_rd_mux, a DEPTH:1 WIDTH-bit selector with the bypass compare and out-of-range zeroing; the top SHALL generate NRD instances and the output registers.

Verification
REQ-030 The bench SHALL write value k to register k for k=1..31, then read all 32 addresses on port 0 -> rdata0=k after 1 cycle, address 0 returns 0.
REQ-031 The bench SHALL write 0xDEADBEEF to addr 5 while port 1 reads addr 5 in the same cycle -> next cycle rdata1=0xDEADBEEF, rvalid1=1.
REQ-032 With ZERO_REG=1, the bench SHALL write 0x1234 to addr 0, then read addr 0 -> 0, err=0.
REQ-033 With DEPTH=24, the bench SHALL write to addr 30, then read addr 30 -> rdata=0, err=1 and held; regs 0..23 unchanged.
REQ-034 The bench SHALL fill all registers, assert rst for 1 cycle concurrent with we=1 at addr 3, then read addr 3 -> 0, with rvalid=0 and err=0 during reset.
REQ-035 With NRD=4, the bench SHALL drive ren=4'b1010 with ports reading addrs 7,7,9,9 -> rvalid=4'b1010, rdata1=reg7, rdata3=reg9, rdata0 and rdata2 hold.
